// File: rtl/regfile_seq.sv
// regfile_seq: sequencer and arbiter for the Y86-64 register file.
// Owns the 15x64 register storage. It serialises decode reads (srcA/srcB
// derived from icode/rA/rB) and writeback writes (dstE/dstM), so the storage
// sees at most one read and one write per cycle.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   dec_req, icode, rA, rB   decode request (level) and its fields
//   dec_ready             high in IDLE; decode accepted if dec_req && !wb_req
//   valA, valB            registered operands, hold between transactions
//   dec_valid             one-cycle pulse when valA/valB are valid
//   wb_req, dstE, dstM, valE, valM   writeback request (level), 4'hF = none
//   wb_ready              high in IDLE
//   wb_done               one-cycle pulse after both writes committed
//
// state | meaning
// IDLE  | waiting; writeback wins over decode
// RD_A  | read srcA into valA
// RD_B  | read srcB into valB, pulse dec_valid
// WR_E  | commit dstE write
// WR_M  | commit dstM write (overrides E on same dst), pulse wb_done
module regfile_seq #(
    parameter logic [63:0] RSP_INIT = 64'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dec_req,
    input  logic [3:0]  icode,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    output logic        dec_ready,
    output logic [63:0] valA,
    output logic [63:0] valB,
    output logic        dec_valid,
    input  logic        wb_req,
    input  logic [3:0]  dstE,
    input  logic [3:0]  dstM,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    output logic        wb_ready,
    output logic        wb_done
);

    typedef enum logic [2:0] {IDLE, RD_A, RD_B, WR_E, WR_M} state_t;

    state_t      state;
    logic [63:0] regs [0:14];
    logic [3:0]  icode_q, ra_q, rb_q;
    logic [3:0]  dst_e_q, dst_m_q;
    logic [63:0] val_e_q, val_m_q;
    logic [3:0]  src_a, src_b;

    // Source selection works from the latched fields so the request inputs
    // are free to change once accepted.
    always_comb begin
        src_a = 4'hF;
        case (icode_q)
            4'h2, 4'h4, 4'h6, 4'hA: src_a = ra_q;
            4'h9, 4'hB:             src_a = 4'h4;
            default:                src_a = 4'hF;
        endcase
    end

    always_comb begin
        src_b = 4'hF;
        case (icode_q)
            4'h4, 4'h5, 4'h6:       src_b = rb_q;
            4'h8, 4'h9, 4'hA, 4'hB: src_b = 4'h4;
            default:                src_b = 4'hF;
        endcase
    end

    assign dec_ready = (state == IDLE);
    assign wb_ready  = (state == IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            valA      <= 64'd0;
            valB      <= 64'd0;
            dec_valid <= 1'b0;
            wb_done   <= 1'b0;
            icode_q   <= 4'h0;
            ra_q      <= 4'hF;
            rb_q      <= 4'hF;
            dst_e_q   <= 4'hF;
            dst_m_q   <= 4'hF;
            val_e_q   <= 64'd0;
            val_m_q   <= 64'd0;
            for (int i = 0; i < 15; i++) begin
                regs[i] <= (i == 4) ? RSP_INIT : 64'd0;
            end
        end else begin
            dec_valid <= 1'b0;
            wb_done   <= 1'b0;
            case (state)
                IDLE: begin
                    // Writeback first keeps a pending decode behind the write.
                    if (wb_req) begin
                        dst_e_q <= dstE;
                        dst_m_q <= dstM;
                        val_e_q <= valE;
                        val_m_q <= valM;
                        state   <= WR_E;
                    end else if (dec_req) begin
                        icode_q <= icode;
                        ra_q    <= rA;
                        rb_q    <= rB;
                        state   <= RD_A;
                    end
                end
                RD_A: begin
                    valA  <= (src_a == 4'hF) ? 64'd0 : regs[src_a];
                    state <= RD_B;
                end
                RD_B: begin
                    valB      <= (src_b == 4'hF) ? 64'd0 : regs[src_b];
                    dec_valid <= 1'b1;
                    state     <= IDLE;
                end
                WR_E: begin
                    if (dst_e_q != 4'hF) regs[dst_e_q] <= val_e_q;
                    state <= WR_M;
                end
                WR_M: begin
                    if (dst_m_q != 4'hF) regs[dst_m_q] <= val_m_q;
                    wb_done <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_seq.sv
// tb_regfile_seq: scoreboard bench for regfile_seq. Stimulus pushes expected
// results when a request is accepted; a negedge monitor pops and compares
// whenever dec_valid or wb_done is seen.
module tb_regfile_seq;

    localparam logic [63:0] RSP = 64'h100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        dec_req = 1'b0;
    logic [3:0]  icode = 4'h0, rA = 4'h0, rB = 4'h0;
    logic        dec_ready;
    logic [63:0] valA, valB;
    logic        dec_valid;
    logic        wb_req = 1'b0;
    logic [3:0]  dstE = 4'hF, dstM = 4'hF;
    logic [63:0] valE = 64'd0, valM = 64'd0;
    logic        wb_ready;
    logic        wb_done;

    regfile_seq #(.RSP_INIT(RSP)) dut (
        .clk(clk), .reset(reset),
        .dec_req(dec_req), .icode(icode), .rA(rA), .rB(rB),
        .dec_ready(dec_ready), .valA(valA), .valB(valB), .dec_valid(dec_valid),
        .wb_req(wb_req), .dstE(dstE), .dstM(dstM), .valE(valE), .valM(valM),
        .wb_ready(wb_ready), .wb_done(wb_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    logic [63:0] model [0:14];

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        int          cyc;
    } dec_exp_t;

    dec_exp_t dec_q[$];
    int       wb_q[$];
    dec_exp_t mon_e;
    int       mon_c;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 15; i++) model[i] = (i == 4) ? RSP : 64'd0;
    endtask

    function automatic logic [63:0] rd(input logic [3:0] s);
        return (s == 4'hF) ? 64'd0 : model[s];
    endfunction

    function automatic logic [3:0] src_a_of(input logic [3:0] ic, input logic [3:0] r);
        if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return r;
        if (ic inside {4'h9, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] src_b_of(input logic [3:0] ic, input logic [3:0] r);
        if (ic inside {4'h4, 4'h5, 4'h6}) return r;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    // Monitor: any pulse without a queued expectation is an error.
    always @(negedge clk) begin
        if (!reset && dec_valid) begin
            if (dec_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL dec_valid_unexpected actual=1 expected=0 cyc=%0d", cyc);
            end else begin
                mon_e = dec_q.pop_front();
                check("valA", valA, mon_e.a);
                check("valB", valB, mon_e.b);
                check("dec_latency", 64'(cyc), 64'(mon_e.cyc));
            end
        end
        if (!reset && wb_done) begin
            if (wb_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL wb_done_unexpected actual=1 expected=0 cyc=%0d", cyc);
            end else begin
                mon_c = wb_q.pop_front();
                check("wb_latency", 64'(cyc), 64'(mon_c));
            end
        end
    end

    // Holds the requested transactions until each is accepted. Acceptance is
    // predicted at the negedge before the edge that takes it.
    task automatic run_req(input bit do_wb, input bit do_dec,
                           input logic [3:0] de, input logic [3:0] dm,
                           input logic [63:0] ve, input logic [63:0] vm,
                           input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb);
        bit wb_p;
        bit dec_p;
        bit acc_wb;
        bit acc_dec;
        int n;
        wb_p = do_wb;
        dec_p = do_dec;
        n = 0;
        @(negedge clk);
        if (do_wb) begin
            dstE = de; dstM = dm; valE = ve; valM = vm; wb_req = 1'b1;
        end
        if (do_dec) begin
            icode = ic; rA = ra; rB = rb; dec_req = 1'b1;
        end
        while ((wb_p || dec_p) && n < 100) begin
            acc_wb = 1'b0;
            acc_dec = 1'b0;
            if (dec_ready && wb_p) acc_wb = 1'b1;
            else if (dec_ready && dec_p) acc_dec = 1'b1;
            if (acc_wb) begin
                if (de != 4'hF) model[de] = ve;
                if (dm != 4'hF) model[dm] = vm;
                wb_q.push_back(cyc + 3);
            end
            if (acc_dec) begin
                dec_q.push_back('{a: rd(src_a_of(ic, ra)), b: rd(src_b_of(ic, rb)), cyc: cyc + 3});
            end
            @(posedge clk);
            #1;
            if (acc_wb) begin
                wb_req = 1'b0; wb_p = 1'b0;
                dstE = 4'($urandom); dstM = 4'($urandom);
                valE = {$urandom, $urandom}; valM = {$urandom, $urandom};
            end
            if (acc_dec) begin
                dec_req = 1'b0; dec_p = 1'b0;
                icode = 4'($urandom); rA = 4'($urandom); rB = 4'($urandom);
            end
            @(negedge clk);
            n++;
        end
        if (wb_p || dec_p) begin
            tests++; fails++;
            $display("FAIL accept_timeout actual=not_accepted expected=accepted");
            wb_req = 1'b0;
            dec_req = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((dec_q.size() != 0 || wb_q.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (dec_q.size() != 0 || wb_q.size() != 0) begin
            tests++; fails++;
            $display("FAIL drain_timeout actual=%0d/%0d pending expected=0/0", dec_q.size(), wb_q.size());
            dec_q.delete();
            wb_q.delete();
        end
    endtask

    task automatic dec(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb);
        run_req(1'b0, 1'b1, 4'hF, 4'hF, 64'd0, 64'd0, ic, ra, rb);
    endtask

    task automatic wb(input logic [3:0] de, input logic [3:0] dm, input logic [63:0] ve, input logic [63:0] vm);
        run_req(1'b1, 1'b0, de, dm, ve, vm, 4'h0, 4'h0, 4'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_valA", valA, 64'd0);
        check("rst_valB", valB, 64'd0);
        check("rst_dec_valid", 64'(dec_valid), 64'd0);
        check("rst_wb_done", 64'(wb_done), 64'd0);
        check("rst_dec_ready", 64'(dec_ready), 64'd1);
        check("rst_wb_ready", 64'(wb_ready), 64'd1);
        reset = 1'b0;

        // Reset register values: ret reads %rsp twice, others read zero.
        dec(4'h9, 4'h0, 4'h0);
        dec(4'h6, 4'h1, 4'hE);
        dec(4'h6, 4'h0, 4'h3);

        // Write then OPq.
        wb(4'h2, 4'h3, 64'h11, 64'h22);
        dec(4'h6, 4'h2, 4'h3);

        // Same destination: M wins; F/F changes nothing.
        wb(4'h5, 4'h5, 64'hAA, 64'hBB);
        dec(4'h6, 4'h5, 4'h5);
        wb(4'hF, 4'hF, 64'h1234, 64'h5678);
        dec(4'h6, 4'h5, 4'h5);

        // Simultaneous requests: writeback first, decode sees the new value.
        run_req(1'b1, 1'b1, 4'h7, 4'hF, 64'h55, 64'h99, 4'hA, 4'h7, 4'h0);

        // Halt/nop read nothing even with nonzero R2/R3.
        dec(4'h0, 4'h2, 4'h3);
        dec(4'h1, 4'h2, 4'h3);
        drain();

        // Randomized mix of decode, writeback and simultaneous requests.
        for (int k = 0; k < 80; k++) begin
            int kind;
            kind = $urandom_range(0, 2);
            run_req(kind != 0, kind != 1,
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    {$urandom, $urandom}, {$urandom, $urandom},
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) drain();
        end
        drain();

        // Reset during WR_M after the dstE write: no wb_done, storage restored.
        @(negedge clk);
        dstE = 4'h6; valE = 64'hDEAD_BEEF; dstM = 4'h7; valM = 64'hCAFE; wb_req = 1'b1;
        @(posedge clk);
        #1;
        wb_req = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("midrst_dec_ready", 64'(dec_ready), 64'd1);
        check("midrst_valA", valA, 64'd0);
        check("midrst_valB", valB, 64'd0);
        check("midrst_wb_done", 64'(wb_done), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        dec(4'h6, 4'h6, 4'h7);
        dec(4'hB, 4'h0, 4'h0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile_seq.md
# regfile_seq

Sequencer and arbiter for the Y86-64 register file. It owns the 15×64 register storage and enforces one read and one write per cycle. It shares that storage between decode requests (srcA/srcB reads derived from icode/rA/rB) and writeback requests (dstE/dstM writes). It sits between the decode stage and the writeback stage of the sequential processor and returns valA/valB with a fixed latency.

## Interface
- RSP_INIT, 64'd0, reset value of register 4 (%rsp); all other registers reset to 0.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- dec_req  in  1  decode request, level; held until accepted.
- icode  in  4  instruction code, sampled at acceptance.
- rA  in  4  register A field, sampled at acceptance.
- rB  in  4  register B field, sampled at acceptance.
- dec_ready  out  1  high when FSM is IDLE; a decode request is accepted on an edge where dec_req && dec_ready && !wb_req.
- valA  out  64  registered operand A; holds its value between transactions.
- valB  out  64  registered operand B; holds its value between transactions.
- dec_valid  out  1  one-cycle pulse; valA/valB are valid in that cycle.
- wb_req  in  1  writeback request, level; held until accepted.
- dstE  in  4  E destination, 4'hF = none.
- dstM  in  4  M destination, 4'hF = none.
- valE  in  64  E write data.
- valM  in  64  M write data.
- wb_ready  out  1  high when FSM is IDLE.
- wb_done  out  1  one-cycle pulse after both writes are committed.

## Operation
- States are IDLE, RD_A, RD_B, WR_E, WR_M. Each non-IDLE state lasts exactly one cycle.
- **IDLE**
  - If wb_req, go to WR_E and latch dstE/dstM/valE/valM.
  - Otherwise, if dec_req, go to RD_A and latch icode/rA/rB.
  - Writeback has priority when both requests are high. This guarantees read-after-write ordering.
- **srcA selection**
  - rA for icode 2, 4, 6, A.
  - 4'h4 for icode 9, B.
  - 4'hF for all other icodes.
- **srcB selection**
  - rB for icode 4, 5, 6.
  - 4'h4 for icode 8, 9, A, B.
  - 4'hF for all other icodes.
- **RD_A:** valA <= (srcA==F) ? 0 : R[srcA]; go to RD_B.
- **RD_B:** valB <= (srcB==F) ? 0 : R[srcB]; go to IDLE; dec_valid <= 1.
- **WR_E:** if dstE != F then R[dstE] <= valE; go to WR_M.
- **WR_M:** if dstM != F then R[dstM] <= valM; go to IDLE; wb_done <= 1.
  - If dstE == dstM, valM is the final value (M wins).
- The storage port is accessed at most once for read and once for write per cycle. Reads and writes never overlap, because the FSM serialises them.
- Unlisted icodes (including 0, 1, 3, 7, C–F) still take the full RD_A/RD_B sequence, with valA = valB = 0 unless the source rules above select a register.

## Timing
- **Reset** (asynchronous; takes effect immediately and overrides any in-progress transaction):
  - state = IDLE.
  - valA = valB = 0.
  - dec_valid = wb_done = 0.
  - R[4] = RSP_INIT; all other R = 0.
  - Any partial writeback is abandoned.
- **Decode latency:** accepted at edge E0. valA updates at E1, valB at E2. dec_valid is high for the cycle between E2 and E3.
- **Writeback latency:** accepted at E0. The dstE write occurs at E1, the dstM write at E2. wb_done is high for the cycle between E2 and E3.
- **Ready and back-to-back:** dec_ready and wb_ready are combinational from state (== IDLE). A new request can be accepted at E2+1, in the same cycle that dec_valid or wb_done is high. Peak throughput is one transaction per 3 cycles.
- **Request hold and withdrawal:** requests not accepted must be held. A request withdrawn before acceptance produces no side effects. Inputs may change freely after acceptance.
- **Write visibility:** a decode accepted in the IDLE cycle right after wb_done observes both new values.

## Test plan
- **Reset values:** reset with RSP_INIT=64'h100, then decode icode=9 (ret) → dec_valid 3 cycles after acceptance, valA=valB=64'h100; all other registers read 0.
- **Write then OPq:** wb dstE=2 valE=64'h11, dstM=3 valM=64'h22; then decode icode=6 rA=2 rB=3 → valA=64'h11, valB=64'h22.
- **Same-destination write:** wb dstE=dstM=5, valE=64'hAA, valM=64'hBB; then decode icode=6 rA=5 rB=5 → valA=valB=64'hBB. A separate wb with dstE=dstM=F changes nothing.
- **Simultaneous requests:** assert dec_req (icode=A, rA=7, rB=0) and wb_req (dstE=7, valE=64'h55) in the same IDLE cycle → WR_E/WR_M run first, then decode returns valA=64'h55 and valB=R[4].
- **Halt/nop:** decode icode=0 and icode=1 with rA=2 rB=3 → valA=valB=0 after R[2] and R[3] have been written nonzero.
- **Reset mid-operation:** assert reset in WR_M after the WR_E write → state IDLE, all registers back to reset values, wb_done never pulses. A subsequent read of dstE returns 0.
